// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku search tiles.
//   GRID_LEN      : number of candidate values per cell (one-hot bus width)
//   tile_state_e  : search FSM state encoding
//   rotl1         : rotate a GRID_LEN one-hot vector left by one, MSB wraps to bit 0
//   lowest_set    : isolate the lowest set bit; an all-zero input yields bit 0
package sudoku_pkg;

  localparam int GRID_LEN = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN     = 2'd1,
    ST_DONE_FWD = 2'd2,
    ST_DONE_BAK = 2'd3
  } tile_state_e;

  function automatic logic [GRID_LEN-1:0] rotl1(input logic [GRID_LEN-1:0] x);
    return {x[GRID_LEN-2:0], x[GRID_LEN-1]};
  endfunction

  function automatic logic [GRID_LEN-1:0] lowest_set(input logic [GRID_LEN-1:0] x);
    logic [GRID_LEN-1:0] r;
    r = x & (~x + GRID_LEN'(1));
    if (r == '0) r = GRID_LEN'(1);
    return r;
  endfunction

endpackage

// File: rtl/search_tile_rotator.sv
// onehot_rotator: combinational helper for the search pointer.
//   ptr_i     : current one-hot pointer
//   rowbias_i : requested start position for a fresh search
//   rot_o     : ptr_i rotated left by one (bit LEN-1 wraps to bit 0)
//   pick_o    : lowest set bit of rowbias_i, or bit 0 when rowbias_i is zero
module onehot_rotator
  import sudoku_pkg::*;
#(
  parameter int LEN = GRID_LEN
) (
  input  logic [LEN-1:0] ptr_i,
  input  logic [LEN-1:0] rowbias_i,
  output logic [LEN-1:0] rot_o,
  output logic [LEN-1:0] pick_o
);

  logic [LEN-1:0] iso;

  assign rot_o  = {ptr_i[LEN-2:0], ptr_i[LEN-1]};
  // x & -x isolates the lowest set bit; zero falls back to bit 0
  assign iso    = rowbias_i & (~rowbias_i + LEN'(1));
  assign pick_o = (rowbias_i == '0) ? LEN'(1) : iso;

endmodule

// File: rtl/search_tile.sv
// search_tile: one cell of a token-passing backtracking sudoku solver.
// On a token pulse the tile scans its candidate values, one per cycle, starting
// either at rowbias (fresh descent) or just past its last committed value.
// The first value not held by a peer and not already tried this descent is
// committed and the token goes forward; if all LEN candidates are blocked the
// tile clears itself and sends the token back.
//
// Token handshake: myturn_i is a single-cycle pulse accepted only in IDLE
// (ignored otherwise, nothing is queued). Exactly one of passfwd_o / passbak_o
// answers each accepted token, as a single-cycle pulse; updaterowbias_o
// accompanies passbak_o. All outputs come from registers.
//
// Ports:
//   clock_i         : clock, rising edge
//   reset_i         : synchronous active-low reset
//   myturn_i        : token pulse, starts a search
//   occupiedmask_i  : values held by peer tiles, sampled each SCAN cycle
//   rowbias_i       : one-hot start position for a fresh search
//   value_o         : committed one-hot value, zero when empty
//   passfwd_o       : commit pulse
//   passbak_o       : exhaustion pulse
//   updaterowbias_o : request for a new rowbias, with passbak_o
//   retries_o       : saturating exhaustion count
//   giveup_o        : high while retries_o == MAX_RETRY
//   state_o         : FSM state (debug)
module search_tile
  import sudoku_pkg::*;
#(
  parameter int LEN       = GRID_LEN,
  parameter int MAX_RETRY = 15,
  parameter int RETRY_W   = $clog2(MAX_RETRY + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               myturn_i,
  input  logic [LEN-1:0]     occupiedmask_i,
  input  logic [LEN-1:0]     rowbias_i,
  output logic [LEN-1:0]     value_o,
  output logic               passfwd_o,
  output logic               passbak_o,
  output logic               updaterowbias_o,
  output logic [RETRY_W-1:0] retries_o,
  output logic               giveup_o,
  output logic [1:0]         state_o
);

  localparam int STEP_W = $clog2(LEN + 1);

  tile_state_e        state_q, state_d;
  logic [LEN-1:0]     ptr_q, ptr_d;
  logic [LEN-1:0]     tried_q, tried_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [LEN-1:0]     value_q, value_d;
  logic [RETRY_W-1:0] retries_q, retries_d;

  logic [LEN-1:0]     ptr_rot;
  logic [LEN-1:0]     ptr_pick;

  onehot_rotator #(.LEN(LEN)) u_rot (
    .ptr_i     (ptr_q),
    .rowbias_i (rowbias_i),
    .rot_o     (ptr_rot),
    .pick_o    (ptr_pick)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      tried_q   <= '0;
      step_q    <= '0;
      value_q   <= '0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tried_q   <= tried_d;
      step_q    <= step_d;
      value_q   <= value_d;
      retries_q <= retries_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tried_d   = tried_q;
    step_d    = step_q;
    value_d   = value_q;
    retries_d = retries_q;

    unique case (state_q)
      ST_IDLE: begin
        if (myturn_i) begin
          state_d = ST_SCAN;
          step_d  = '0;
          // an empty tried mask means a fresh descent: restart from rowbias;
          // otherwise resume just past the value committed last time
          ptr_d   = (tried_q == '0) ? ptr_pick : ptr_rot;
        end
      end
      ST_SCAN: begin
        if ((ptr_q & (occupiedmask_i | tried_q)) == '0) begin
          value_d = ptr_q;
          tried_d = tried_q | ptr_q;
          state_d = ST_DONE_FWD;
        end else if (step_q == STEP_W'(LEN - 1)) begin
          value_d = '0;
          tried_d = '0;
          state_d = ST_DONE_BAK;
          if (retries_q != RETRY_W'(MAX_RETRY)) retries_d = retries_q + RETRY_W'(1);
        end else begin
          ptr_d  = ptr_rot;
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE_FWD: state_d = ST_IDLE;
      ST_DONE_BAK: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign value_o         = value_q;
  assign passfwd_o       = (state_q == ST_DONE_FWD);
  assign passbak_o       = (state_q == ST_DONE_BAK);
  assign updaterowbias_o = (state_q == ST_DONE_BAK);
  assign retries_o       = retries_q;
  assign giveup_o        = (retries_q == RETRY_W'(MAX_RETRY));
  assign state_o         = state_q;

endmodule

// File: tb/tb_search_tile.sv
// Bench for search_tile (LEN=9, MAX_RETRY=3): directed scenarios followed by
// random searches. Each token issued pushes the expected pulse (kind, value,
// retries, giveup, cycle) onto exp_q; a monitor pops on every DUT pulse.
module tb_search_tile;

  localparam int LEN       = 9;
  localparam int MAX_RETRY = 3;
  localparam int RW        = 2;
  localparam int W         = 3 + LEN + RW + 1 + 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            myturn = 1'b0;
  logic [LEN-1:0]  occupiedmask = '0;
  logic [LEN-1:0]  rowbias = '0;
  logic [LEN-1:0]  value;
  logic            passfwd, passbak, updrb, giveup;
  logic [RW-1:0]   retries;
  logic [1:0]      dbg_state;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  logic [W-1:0] exp_q[$];

  // reference model state
  logic [LEN-1:0] m_tried = '0;
  int             m_ptr = 0;
  int             m_retries = 0;

  search_tile #(.LEN(LEN), .MAX_RETRY(MAX_RETRY)) dut (
    .clock_i         (clk),
    .reset_i         (rst_n),
    .myturn_i        (myturn),
    .occupiedmask_i  (occupiedmask),
    .rowbias_i       (rowbias),
    .value_o         (value),
    .passfwd_o       (passfwd),
    .passbak_o       (passbak),
    .updaterowbias_o (updrb),
    .retries_o       (retries),
    .giveup_o        (giveup),
    .state_o         (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", passes, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_reset();
    m_tried   = '0;
    m_ptr     = 0;
    m_retries = 0;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_value"},   64'(value),   64'(0));
    check({tag, "_passfwd"}, 64'(passfwd), 64'(0));
    check({tag, "_passbak"}, 64'(passbak), 64'(0));
    check({tag, "_updrb"},   64'(updrb),   64'(0));
    check({tag, "_retries"}, 64'(retries), 64'(0));
    check({tag, "_giveup"},  64'(giveup),  64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    myturn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_reset_state("reset");
  endtask

  // driver: one token pulse; the model decides the expected answer up front
  task automatic issue_search(input logic [LEN-1:0] occ, input logic [LEN-1:0] rb,
                              input bit extra);
    int t, start, k_hit, idx;
    logic [LEN-1:0] blocked, val;
    @(negedge clk);
    occupiedmask = occ;
    rowbias = rb;
    myturn = 1'b1;
    t = cyc;
    if (m_tried == '0) begin
      start = 0;
      for (int i = LEN - 1; i >= 0; i--) if (rb[i]) start = i;
    end else begin
      start = (m_ptr + 1) % LEN;
    end
    blocked = occ | m_tried;
    k_hit = 0;
    for (int k = 1; k <= LEN; k++)
      if (k_hit == 0 && !blocked[(start + k - 1) % LEN]) k_hit = k;
    if (k_hit != 0) begin
      idx = (start + k_hit - 1) % LEN;
      m_ptr = idx;
      m_tried[idx] = 1'b1;
      val = '0;
      val[idx] = 1'b1;
      exp_q.push_back({3'b100, val, RW'(m_retries), m_retries == MAX_RETRY, 32'(t + k_hit + 1)});
    end else begin
      m_tried = '0;
      if (m_retries < MAX_RETRY) m_retries++;
      exp_q.push_back({3'b011, {LEN{1'b0}}, RW'(m_retries), m_retries == MAX_RETRY,
                       32'(t + LEN + 1)});
    end
    @(negedge clk);
    myturn = 1'b0;
    if (extra) begin
      // the tile is busy in this cycle whatever k is, so this must be ignored
      @(negedge clk);
      myturn = 1'b1;
      @(negedge clk);
      myturn = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL timeout: %0d responses still pending after %0d cycles, want 0",
               exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] a, e;
    forever begin
      @(negedge clk);
      if (passfwd || passbak || updrb) begin
        a = {passfwd, passbak, updrb, value, retries, giveup, 32'(cyc)};
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: fwd=%0b bak=%0b updrb=%0b at cycle %0d, want no pulse",
                   passfwd, passbak, updrb, cyc);
        end else begin
          e = exp_q.pop_front();
          check("response", 64'(a), 64'(e));
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [LEN-1:0] occ, rb;
    do_reset();

    // start at bit 2 (blocked), commit bit 3
    issue_search(9'b000000100, 9'b000000100, 1'b0);
    wait_idle();
    #1 check("v_first", 64'(value), 64'(9'b000001000));

    // immediate re-entry resumes at bit 4
    issue_search(9'h000, 9'b000000100, 1'b0);
    wait_idle();
    #1 check("v_reentry", 64'(value), 64'(9'b000010000));

    // wrap-around from bit 8 to bit 0
    do_reset();
    issue_search(9'h1FE, 9'b100000000, 1'b0);
    wait_idle();
    #1 check("v_wrap", 64'(value), 64'(9'b000000001));

    // four exhaustions: retries 1,2,3 then saturate
    for (int i = 1; i <= 4; i++) begin
      issue_search(9'h1FF, 9'b000000001, 1'b0);
      wait_idle();
      #1;
      check("exh_value",   64'(value),   64'(0));
      check("exh_retries", 64'(retries), 64'((i > MAX_RETRY) ? MAX_RETRY : i));
      check("exh_giveup",  64'(giveup),  64'(i >= MAX_RETRY));
    end

    // reset in the middle of a full scan, with an ignored token at t+2
    @(negedge clk);
    occupiedmask = 9'h1FF;
    myturn = 1'b1;
    @(negedge clk);
    myturn = 1'b0;
    @(negedge clk);
    myturn = 1'b1;
    @(negedge clk);
    myturn = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (12) @(negedge clk);
    check_reset_state("midscan");
    check("midscan_state", 64'(dbg_state), 64'(0));
    // tried and ptr must be cleared: a fresh search starts from rowbias
    issue_search(9'h000, 9'b000100000, 1'b0);
    wait_idle();
    #1 check("v_after_reset", 64'(value), 64'(9'b000100000));

    // random searches
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      case ($urandom_range(0, 5))
        0:       occ = 9'h1FF;
        1:       occ = 9'h000;
        default: occ = LEN'($urandom_range(0, 511));
      endcase
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1: begin
          rb = '0;
          rb[$urandom_range(0, LEN - 1)] = 1'b1;
        end
        default: rb = LEN'($urandom_range(0, 511));
      endcase
      issue_search(occ, rb, $urandom_range(0, 3) == 0);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
